// File: rtl/bus_arbiter_param_pkg.sv
// Shared types and helpers for the parametrised system-bus arbiter.
// Contents:
//   arb_state_t  - arbiter FSM states (IDLE, GRANTED, BUSY)
//   MID_NONE     - master code broadcast when no master holds the bus
//   to_code      - master index -> master code (index+1)
//   from_code    - master code -> master index (code-1)
package bus_arbiter_param_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    BUSY
  } arb_state_t;

  localparam int MID_NONE = 0;

  // Code 0 is reserved for "no master", so codes are offset by one.
  function automatic int to_code(int idx);
    return idx + 1;
  endfunction

  function automatic int from_code(int code);
    return code - 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_param_if.sv
// Bundle of the arbiter's request/grant/split signals.
// Modports:
//   master - arbiter side: takes requests, utilisation and slave split
//            traffic; drives grants, slave notify fields, split mask and
//            the hold-timeout pulse
//   slave  - agent side (masters and slaves of the bus), mirror image
interface bus_arbiter_param_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3
);
  localparam int MID_W = $clog2(NUM_MASTERS + 1);

  logic                          rr_mode;
  logic [NUM_MASTERS-1:0]        req_from_master;
  logic [NUM_MASTERS-1:0]        bus_utilization;
  logic [NUM_MASTERS-1:0]        grant_to_master;
  logic [NUM_SLAVES*MID_W-1:0]   notify_granted_master_to_slave;
  logic [NUM_SLAVES*MID_W-1:0]   split_req_from_slave;
  logic [NUM_SLAVES-1:0]         split_release_from_slave;
  logic [NUM_MASTERS-1:0]        split_pending;
  logic                          hold_timeout;

  modport master (
    input  rr_mode,
    input  req_from_master,
    input  bus_utilization,
    input  split_req_from_slave,
    input  split_release_from_slave,
    output grant_to_master,
    output notify_granted_master_to_slave,
    output split_pending,
    output hold_timeout
  );

  modport slave (
    output rr_mode,
    output req_from_master,
    output bus_utilization,
    output split_req_from_slave,
    output split_release_from_slave,
    input  grant_to_master,
    input  notify_granted_master_to_slave,
    input  split_pending,
    input  hold_timeout
  );

endinterface

// File: rtl/bus_arbiter_param_pick.sv
// Combinational winner selection for the bus arbiter.
// Ports:
//   eligible  in   NUM_MASTERS  requesting masters that are not parked
//   rr_mode   in   1            0 = highest index wins, 1 = round robin
//   rr_ptr    in   IDX_W        index of the last round-robin winner
//   winner    out  IDX_W        selected master index (0 when none)
//   valid     out  1            at least one master is eligible
module bus_arbiter_param_pick #(
  parameter  int NUM_MASTERS = 2,
  localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] eligible,
  input  logic                   rr_mode,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [IDX_W-1:0]       winner,
  output logic                   valid
);

  logic             found;
  logic [IDX_W-1:0] cand;

  assign valid = |eligible;

  // Round robin walks the masters starting just after the last winner and
  // wraps, so the previous winner is considered last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    if (!rr_mode) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (eligible[i]) begin
          winner = IDX_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        cand = IDX_W'((int'(rr_ptr) + k) % NUM_MASTERS);
        if (!found && eligible[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_param.sv
// Shared serial-bus arbiter for NUM_MASTERS masters and NUM_SLAVES slaves.
// Grants one master at a time (fixed priority or round robin, chosen when
// idle), revokes grants that are never used or held too long while others
// wait, and parks masters that a slave has split until that slave releases.
// Ports:
//   clk    in  1  system clock
//   reset  in  1  synchronous, active-low reset
//   bus    bus_arbiter_param_if.master: requests, utilisation, split and
//          release traffic in; grants, per-slave master code, split mask
//          and hold-timeout pulse out
module bus_arbiter_param
  import bus_arbiter_param_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int GRANT_WAIT  = 4,
  parameter int MAX_HOLD    = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_arbiter_param_if.master  bus
);

  localparam int MID_W  = $clog2(NUM_MASTERS + 1);
  localparam int IDX_W  = $clog2(NUM_MASTERS);
  localparam int SIDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int WAIT_W = $clog2(GRANT_WAIT + 1);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_t             state;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [NUM_MASTERS-1:0] pending_q;
  logic                   hold_to_q;
  logic [IDX_W-1:0]       gnt_idx;
  logic [IDX_W-1:0]       rr_ptr;
  logic [SIDX_W-1:0]      owner [NUM_MASTERS];
  logic [WAIT_W-1:0]      wait_cnt;
  logic [HOLD_W-1:0]      hold_cnt;

  logic [NUM_MASTERS-1:0] eligible;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [MID_W-1:0]       gnt_code;
  logic [MID_W-1:0]       notify_code;
  logic                   others_waiting;
  logic                   split_hit;
  logic [SIDX_W-1:0]      split_slave;

  assign eligible       = bus.req_from_master & ~pending_q;
  assign gnt_code       = MID_W'(to_code(int'(gnt_idx)));
  assign notify_code    = (|grant_q) ? gnt_code : MID_W'(MID_NONE);
  assign others_waiting = |(eligible & ~grant_q);

  assign bus.grant_to_master                = grant_q;
  assign bus.notify_granted_master_to_slave = {NUM_SLAVES{notify_code}};
  assign bus.split_pending                  = pending_q;
  assign bus.hold_timeout                   = hold_to_q;

  bus_arbiter_param_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_pick (
    .eligible (eligible),
    .rr_mode  (bus.rr_mode),
    .rr_ptr   (rr_ptr),
    .winner   (pick_idx),
    .valid    (pick_valid)
  );

  // Scan downward so the lowest-numbered slave claiming the granted master
  // ends up as the recorded owner. Code 0 never matches gnt_code.
  always_comb begin
    split_hit   = 1'b0;
    split_slave = '0;
    for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
      if (bus.split_req_from_slave[s*MID_W +: MID_W] == gnt_code) begin
        split_hit   = 1'b1;
        split_slave = SIDX_W'(s);
      end
    end
  end

  // Releases are written before the FSM so that a split issued in the same
  // cycle on the same master overrides the clear and keeps it parked.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      grant_q   <= '0;
      pending_q <= '0;
      hold_to_q <= 1'b0;
      gnt_idx   <= '0;
      rr_ptr    <= IDX_W'(NUM_MASTERS - 1);
      wait_cnt  <= '0;
      hold_cnt  <= '0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        owner[m] <= '0;
      end
    end else begin
      hold_to_q <= 1'b0;

      for (int m = 0; m < NUM_MASTERS; m++) begin
        for (int s = 0; s < NUM_SLAVES; s++) begin
          if (bus.split_release_from_slave[s] && owner[m] == SIDX_W'(s)) begin
            pending_q[m] <= 1'b0;
          end
        end
      end

      case (state)
        IDLE: begin
          wait_cnt <= '0;
          hold_cnt <= '0;
          if (pick_valid) begin
            grant_q <= NUM_MASTERS'(1) << pick_idx;
            gnt_idx <= pick_idx;
            if (bus.rr_mode) begin
              rr_ptr <= pick_idx;
            end
            state <= GRANTED;
          end
        end

        GRANTED: begin
          if (bus.bus_utilization[gnt_idx]) begin
            hold_cnt <= '0;
            state    <= BUSY;
          end else if (!bus.req_from_master[gnt_idx]) begin
            grant_q <= '0;
            state   <= IDLE;
          end else if (wait_cnt == WAIT_W'(GRANT_WAIT - 1)) begin
            grant_q <= '0;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        BUSY: begin
          if (split_hit) begin
            pending_q[gnt_idx] <= 1'b1;
            owner[gnt_idx]     <= split_slave;
            grant_q            <= '0;
            state              <= IDLE;
          end else if (!bus.bus_utilization[gnt_idx]) begin
            grant_q <= '0;
            state   <= IDLE;
          end else if (MAX_HOLD != 0 && others_waiting) begin
            // Hold time only accrues while somebody else is kept waiting.
            if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
              grant_q   <= '0;
              hold_to_q <= 1'b1;
              state     <= IDLE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end

        default: begin
          grant_q <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
